t05_bit_stream_arbiter: RTL

T05_BIT_STREAM_ARBITER -- requirements
Module: t05_bit_stream_arbiter

---
 rtl/t05_bit_stream_arbiter_pkg.sv | 30 +++
 rtl/t05_bit_stream_arbiter_if.sv | 15 +
 rtl/t05_bit_packer.sv | 82 ++++++++
 rtl/t05_bit_stream_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/t05_bit_stream_arbiter_pkg.sv
// Shared types and defaults for the t05 bit-stream arbiter.
package t05_bit_stream_arbiter_pkg;

  localparam int unsigned WORD_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    FLUSH,
    DONE
  } phase_t;

  // Which serial source currently owns the packer.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_HDR,
    SRC_DATA
  } src_t;

  // Maps an arbiter phase to the bit source granted in that phase.
  function automatic src_t state_cb(input phase_t p);
    case (p)
      HEADER:  return SRC_HDR;
      DATA:    return SRC_DATA;
      default: return SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/t05_bit_stream_arbiter_if.sv
// Word handshake toward the SPI writer.
interface t05_bit_stream_arbiter_if
  import t05_bit_stream_arbiter_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEFAULT
) ();

  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);

endinterface

// File: rtl/t05_bit_packer.sv
// MSB-first bit packer: shift register, bit counter and one holding register.
module t05_bit_packer
  import t05_bit_stream_arbiter_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      acc,
  input  logic                      din,
  input  logic                      last,
  output logic                      stall,
  output logic                      pend,
  output logic [$clog2(WORD_W):0]   fill,
  t05_bit_stream_arbiter_if.master  wr
);

  localparam int unsigned CW = $clog2(WORD_W);

  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] base_sreg;
  logic [WORD_W-1:0] nsreg;
  logic [WORD_W-1:0] msb;
  logic [CW:0]       cnt;
  logic [CW:0]       base_cnt;
  logic              hold_free;
  logic              move_pend;
  logic              complete;

  // Next shift-register image; bits are written at their final position so a
  // partial word is already zero-padded. A parked word leaving this cycle
  // frees the shift register for a simultaneous new bit.
  always_comb begin
    hold_free = !wr.word_valid || wr.word_ready;
    move_pend = pend && hold_free;
    stall     = pend && !hold_free;
    base_sreg = move_pend ? '0 : sreg;
    base_cnt  = move_pend ? '0 : cnt;
    msb       = '0;
    msb[WORD_W-1] = din;
    nsreg     = base_sreg | (msb >> base_cnt);
    fill      = base_cnt + (CW+1)'(1);
    complete  = acc && ((fill == (CW+1)'(WORD_W)) || last);
  end

  // Shift register, parked-word flag and holding register with handshake.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sreg          <= '0;
      cnt           <= '0;
      pend          <= 1'b0;
      wr.word_out   <= '0;
      wr.word_valid <= 1'b0;
    end else begin
      if (move_pend) begin
        wr.word_out   <= sreg;
        wr.word_valid <= 1'b1;
        pend          <= 1'b0;
        sreg          <= '0;
        cnt           <= '0;
      end else if (wr.word_valid && wr.word_ready) begin
        wr.word_valid <= 1'b0;
      end
      if (complete) begin
        if (hold_free && !move_pend) begin
          wr.word_out   <= nsreg;
          wr.word_valid <= 1'b1;
          sreg          <= '0;
          cnt           <= '0;
        end else begin
          sreg <= nsreg;
          cnt  <= fill;
          pend <= 1'b1;
        end
      end else if (acc) begin
        sreg <= nsreg;
        cnt  <= fill;
      end
    end
  end

endmodule

// File: rtl/t05_bit_stream_arbiter.sv
// Arbitrates header and data bit streams into one packed word stream.
module t05_bit_stream_arbiter
  import t05_bit_stream_arbiter_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        start,
  input  logic                        hdr_enable,
  input  logic                        hdr_bit,
  input  logic                        hdr_complete,
  input  logic                        data_enable,
  input  logic                        data_bit,
  input  logic                        data_last,
  t05_bit_stream_arbiter_if.master    wr,
  output logic                        stall,
  output logic                        reject,
  output logic                        overflow,
  output logic [$clog2(WORD_W)-1:0]   pad_bits,
  output phase_t                      phase,
  output logic                        done
);

  localparam int unsigned CW = $clog2(WORD_W);

  src_t        src;
  logic        hdr_grant;
  logic        data_grant;
  logic        hdr_take;
  logic        data_take;
  logic        acc;
  logic        din;
  logic        last;
  logic        stall_drop;
  logic        discard;
  logic        pend;
  logic [CW:0] fill;

  // Grant decode: one source per phase; stalled grants are dropped.
  always_comb begin
    src        = state_cb(phase);
    hdr_grant  = (src == SRC_HDR);
    data_grant = (src == SRC_DATA);
    hdr_take   = hdr_grant && hdr_enable;
    data_take  = data_grant && data_enable;
    acc        = (hdr_take || data_take) && !stall;
    stall_drop = (hdr_take || data_take) && stall;
    din        = hdr_grant ? hdr_bit : data_bit;
    last       = data_grant && data_last;
    discard    = (hdr_enable && !hdr_grant) || (data_enable && !data_grant) || stall_drop;
  end

  t05_bit_packer #(.WORD_W(WORD_W)) u_packer (
    .clk   (clk),
    .nrst  (nrst),
    .acc   (acc),
    .din   (din),
    .last  (last),
    .stall (stall),
    .pend  (pend),
    .fill  (fill),
    .wr    (wr)
  );

  // Phase FSM with registered reject, overflow, pad count and done.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      phase    <= IDLE;
      reject   <= 1'b0;
      overflow <= 1'b0;
      pad_bits <= '0;
      done     <= 1'b0;
    end else begin
      reject <= discard;
      if (stall_drop) overflow <= 1'b1;
      case (phase)
        IDLE, DONE: begin
          if (start) begin
            phase    <= HEADER;
            pad_bits <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
          end
        end
        HEADER: begin
          if (hdr_complete) phase <= DATA;
        end
        DATA: begin
          if (acc && data_last) begin
            phase    <= FLUSH;
            pad_bits <= CW'(WORD_W - int'(fill));
          end
        end
        FLUSH: begin
          if (!pend && wr.word_valid && wr.word_ready) begin
            phase <= DONE;
            done  <= 1'b1;
          end
        end
        default: phase <= IDLE;
      endcase
    end
  end

endmodule
